// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared widths and writeback request type for the writeback arbiter
package reg_wb_arbiter_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy bit per register for outstanding load destinations
module reg_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_set_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_set_rd,
    input  logic                      i_clr_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_clr_rd,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                      o_rs1_busy,
    output logic                      o_rs2_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Set is applied after clear so a freshly issued load keeps the bit high.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_valid) begin
            w_busy_next[i_clr_rd] = 1'b0;
        end
        if (i_set_valid && (i_set_rd != '0)) begin
            w_busy_next[i_set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin EXE/MEM writeback arbiter; WB_SCOREBOARD_EN builds the load scoreboard
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exe_valid,
    output logic                      exe_ready,
    input  logic [REG_ADDR_WIDTH-1:0] exe_rd,
    input  logic [DATA_WIDTH-1:0]     exe_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      sb_set_valid,
    input  logic [REG_ADDR_WIDTH-1:0] sb_set_rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy
);

    logic    r_rr_ptr;
    logic    w_contended;
    logic    w_grant_exe;
    logic    w_grant_mem;
    wb_req_t w_exe_req;
    wb_req_t w_mem_req;
    wb_req_t w_win_req;

    assign w_exe_req   = {exe_rd, exe_data};
    assign w_mem_req   = {mem_rd, mem_data};
    assign w_contended = exe_valid && mem_valid;
    assign w_grant_exe = exe_valid && (!mem_valid || !r_rr_ptr);
    assign w_grant_mem = mem_valid && (!exe_valid || r_rr_ptr);
    assign exe_ready   = w_grant_exe;
    assign mem_ready   = w_grant_mem;
    assign w_win_req   = w_grant_mem ? w_mem_req : w_exe_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_contended) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if ((w_grant_exe || w_grant_mem) && (w_win_req.rd != '0)) begin
            wr_en   <= 1'b1;
            wr_addr <= w_win_req.rd;
            wr_data <= w_win_req.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_valid (sb_set_valid),
        .i_set_rd    (sb_set_rd),
        .i_clr_valid (w_grant_mem),
        .i_clr_rd    (mem_rd),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );
`else
    logic w_sb_unused;
    assign w_sb_unused = ^{sb_set_valid, sb_set_rd, rs1_addr, rs2_addr};
    assign rs1_busy    = 1'b0;
    assign rs2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - randomized scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      exe_valid = 1'b0;
    logic                      exe_ready;
    logic [REG_ADDR_WIDTH-1:0] exe_rd = '0;
    logic [DATA_WIDTH-1:0]     exe_data = '0;
    logic                      mem_valid = 1'b0;
    logic                      mem_ready;
    logic [REG_ADDR_WIDTH-1:0] mem_rd = '0;
    logic [DATA_WIDTH-1:0]     mem_data = '0;
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      sb_set_valid = 1'b0;
    logic [REG_ADDR_WIDTH-1:0] sb_set_rd = '0;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr = '0;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr = '0;
    logic                      rs1_busy;
    logic                      rs2_busy;

    reg_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exe_valid    (exe_valid),
        .exe_ready    (exe_ready),
        .exe_rd       (exe_rd),
        .exe_data     (exe_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sb_set_valid (sb_set_valid),
        .sb_set_rd    (sb_set_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                        due;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } exp_t;

    exp_t                      exp_q[$];
    int                        n_tests = 0;
    int                        n_fail = 0;
    int                        cyc = 0;
    bit                        running = 1'b0;
    bit                        rr_m = 1'b0;
    bit                        busy_m[NUM_REGS];
    logic [REG_ADDR_WIDTH-1:0] last_addr = '0;
    logic [DATA_WIDTH-1:0]     last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit exp_busy(input logic [REG_ADDR_WIDTH-1:0] a);
`ifdef WB_SCOREBOARD_EN
        return busy_m[a];
`else
        return 1'b0 & busy_m[a];
`endif
    endfunction

    // Monitor: registered write port checked against the expected-write queue.
    always @(negedge clk) begin
        exp_t e;
        if (running) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr_en", {31'd0, wr_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_latency", cyc, e.due);
                    check("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
                    check("wr_data", wr_data, e.data);
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("wr_en_missing", {31'd0, wr_en}, 32'd1);
                    void'(exp_q.pop_front());
                end
                check("wr_addr_hold", {27'd0, wr_addr}, {27'd0, last_addr});
                check("wr_data_hold", wr_data, last_data);
            end
        end
    end

    initial begin
        bit e_pend, m_pend, g_e, g_m;
        exp_t e;

        foreach (busy_m[k]) busy_m[k] = 1'b0;
        exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 32'h1234;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        e_pend = 1'b1; m_pend = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        check("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        check("rst_exe_ready", {31'd0, exe_ready}, 32'd1);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        running = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if (!e_pend && $urandom_range(0, 9) < 6) begin
                e_pend = 1'b1;
                exe_rd = REG_ADDR_WIDTH'($urandom_range(0, 7));
                exe_data = $urandom;
            end
            if (!m_pend && $urandom_range(0, 9) < 6) begin
                m_pend = 1'b1;
                mem_rd = REG_ADDR_WIDTH'($urandom_range(0, 7));
                mem_data = $urandom;
            end
            exe_valid = e_pend;
            mem_valid = m_pend;
            sb_set_valid = ($urandom_range(0, 9) < 3);
            sb_set_rd = REG_ADDR_WIDTH'($urandom_range(0, 7));
            rs1_addr = REG_ADDR_WIDTH'($urandom_range(0, 7));
            rs2_addr = REG_ADDR_WIDTH'($urandom_range(0, 7));
            #1;
            g_e = e_pend && (!m_pend || !rr_m);
            g_m = m_pend && (!e_pend || rr_m);
            check("exe_ready", {31'd0, exe_ready}, {31'd0, g_e});
            check("mem_ready", {31'd0, mem_ready}, {31'd0, g_m});
            check("rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
            check("rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});

            if (i % 700 == 350) begin
                // Mid-run reset: pending requests are kept and re-presented afterwards.
                #1;
                rst_n = 1'b0;
                exp_q.delete();
                last_addr = '0;
                last_data = '0;
                rr_m = 1'b0;
                foreach (busy_m[k]) busy_m[k] = 1'b0;
                #1;
                check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
                check("midrst_wr_addr", {27'd0, wr_addr}, 32'd0);
                check("midrst_wr_data", wr_data, 32'd0);
                check("midrst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
                check("midrst_exe_ready", {31'd0, exe_ready}, {31'd0, e_pend});
                @(posedge clk);
                cyc++;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
            end else begin
                if (g_e && exe_rd != '0) begin
                    e.due = cyc + 1; e.addr = exe_rd; e.data = exe_data;
                    exp_q.push_back(e);
                end
                if (g_m && mem_rd != '0) begin
                    e.due = cyc + 1; e.addr = mem_rd; e.data = mem_data;
                    exp_q.push_back(e);
                end
                if (g_m) busy_m[mem_rd] = 1'b0;
                if (sb_set_valid && sb_set_rd != '0) busy_m[sb_set_rd] = 1'b1;
                if (e_pend && m_pend) rr_m = !rr_m;
                if (g_e) e_pend = 1'b0;
                if (g_m) m_pend = 1'b0;
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end

        exe_valid = 1'b0;
        mem_valid = 1'b0;
        sb_set_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
